iori_anim_ctrl: RTL
===================

Name: iori_anim_ctrl

Overview:
- Animation and state controller for the player-2 fighter (Iori).
- Turns keyboard levels and a collision hit pulse into the sprite state code, animation frame index and movement pulses.
- Drives the character2_state, frame_num, move_l2, move_r2, attack and hurt inputs of the downstream sprite renderer.
- All decisions are paced by the ~60 Hz frame clock, resynchronised into the 50 MHz Clk domain.

Parameters:
- FRAME_DIV, 4: frame ticks per animation step (1..15).
- STAND_FRAMES, 8: stand loop length.
- FWD_FRAMES, 10: move-left (forward) loop length.
- BWD_FRAMES, 9: move-right (backward) loop length.
- ATTACK_FRAMES, 6: attack one-shot length.
- DEFENSE_FRAMES, 1: defense loop length.
- HURT_FRAMES, 5: hurt one-shot length.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  ~60 Hz frame clock, asynchronous to Clk.
- key_left  in  1  level, left key held.
- key_right  in  1  level, right key held.
- key_attack  in  1  level, attack key held.
- key_defend  in  1  level, defend key held.
- hit  in  1  one-Clk pulse from collision logic: opponent attack landed.
- character2_state  out  8  state code (STAND=0, ATTACK=1, MOVEL=2, MOVER=3, DEFENSE=4, HURT=5).
- frame_num  out  8  current animation frame index.
- move_l2  out  1  one-Clk pulse per frame tick while in MOVEL.
- move_r2  out  1  one-Clk pulse per frame tick while in MOVER.
- attack  out  1  one-Clk pulse per frame tick while in ATTACK.
- hurt  out  1  one-Clk pulse per frame tick while in HURT.
- blocked  out  1  one-Clk pulse: a hit was absorbed in DEFENSE.

Behaviour:
- Reset, asynchronous: state=STAND, frame_num=0, step counter=0, hit_pending=0, all pulse outputs 0, synchroniser flops 0.
- Tick generation: frame_clk passes through a 2-flop synchroniser, then rising-edge detect, giving tick = one Clk pulse per frame. Tick asserts 3 Clk cycles after the frame_clk edge, ±1 cycle.
- Step: asserted on every FRAME_DIV-th tick; the counter wraps FRAME_DIV-1 -> 0.
- hit handling: a hit pulse sets hit_pending on any Clk cycle. It clears on the next tick, where it is consumed.
- State evaluation happens on every tick, not only on steps, in priority order:
  1. hit_pending and state != HURT and state != DEFENSE -> HURT.
  2. hit_pending and state == DEFENSE -> stay in DEFENSE and pulse blocked.
  3. State is ATTACK or HURT and its last frame has not yet completed -> hold the state (one-shots cannot be interrupted, except ATTACK by rule 1).
  4. key_attack -> ATTACK.
  5. key_defend -> DEFENSE.
  6. key_left xor key_right -> MOVEL for left, MOVER for right.
  7. Otherwise -> STAND, including both direction keys held.
- Any state change: frame_num=0 and step counter=0 in the same cycle.
- No state change and step asserted:
  - Looping states (STAND, MOVEL, MOVER, DEFENSE): frame_num increments and wraps from N-1 to 0.
  - One-shots (ATTACK, HURT): frame_num increments. A step taken while at frame N-1 marks the one-shot complete, and the same tick re-evaluates from rule 4 with frame_num=0.
- Output timing: character2_state and frame_num are registered and update one Clk after the tick.
- Pulse outputs (move_l2, move_r2, attack, hurt, blocked): registered, high for exactly the one Clk following a tick, reflecting the new state.
- frame_num width rule: frame_num never reaches or exceeds the active state's frame count. It is zero-extended to 8 bits.
- hit coinciding with a tick: it is taken in that tick's evaluation.
- Reset asserted mid-animation: immediate return to STAND frame 0, and any pending hit is discarded.

Decomposition:
- Package iori_pkg:
  - state_t enum, logic [7:0], shared with the sprite renderer.
  - Frame-count constants.
  - frames_of(state_t) function.
- Sub-module frame_tick_gen: synchroniser, edge detect and FRAME_DIV step counter. Outputs tick and step.

Test Plan:
- Reset, then 20 frame_clk periods with no keys -> state 0; frame_num sequence 0..7 repeating, advancing every 4 ticks; all pulses stay 0.
- key_left held for 12 ticks -> state 2 one Clk after the first tick; 12 move_l2 pulses; frame_num 0,0,0,0,1,1,1,1,2,2,2,2. After release -> state 0, frame 0.
- key_attack pulsed for 1 tick -> state 1 for 24 ticks (6 frames × 4); 24 attack pulses; then state 0.
- In ATTACK frame 2, hit asserted mid-frame -> next tick gives state 5 and frame 0; 20 hurt pulses; then state 0. A second hit during HURT is ignored.
- key_defend held, then hit -> state stays 4; exactly one blocked pulse; no hurt pulse.
- key_left and key_right held together -> state 0. Reset asserted asynchronously during HURT frame 3 -> outputs are 0 without waiting for a Clk edge.

Source files
------------

// File: rtl/iori_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iori_pkg : state codes and frame counts shared with sprite renderer   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package iori_pkg;

  typedef enum logic [7:0] {
    ST_STAND   = 8'd0,
    ST_ATTACK  = 8'd1,
    ST_MOVEL   = 8'd2,
    ST_MOVER   = 8'd3,
    ST_DEFENSE = 8'd4,
    ST_HURT    = 8'd5
  } state_t;

  localparam int C_STAND_FRAMES   = 8;
  localparam int C_FWD_FRAMES     = 10;
  localparam int C_BWD_FRAMES     = 9;
  localparam int C_ATTACK_FRAMES  = 6;
  localparam int C_DEFENSE_FRAMES = 1;
  localparam int C_HURT_FRAMES    = 5;

  function automatic logic [7:0] frames_of(state_t s);
    case (s)
      ST_ATTACK:  frames_of = 8'(C_ATTACK_FRAMES);
      ST_MOVEL:   frames_of = 8'(C_FWD_FRAMES);
      ST_MOVER:   frames_of = 8'(C_BWD_FRAMES);
      ST_DEFENSE: frames_of = 8'(C_DEFENSE_FRAMES);
      ST_HURT:    frames_of = 8'(C_HURT_FRAMES);
      default:    frames_of = 8'(C_STAND_FRAMES);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_tick_gen : frame_clk resync, rising-edge tick, FRAME_DIV steps  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_tick_gen #(
  parameter int FRAME_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  input  logic clr,
  output logic tick,
  output logic step
);

  localparam logic [3:0] C_LAST = 4'(FRAME_DIV - 1);

  // [1:0] is the synchroniser, [2] is the delayed copy for edge detect
  logic [2:0] r_sync;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 3'd0;
      r_cnt  <= 4'd0;
    end else begin
      r_sync <= {r_sync[1:0], frame_clk};
      if (clr)
        r_cnt <= 4'd0;
      else if (tick)
        r_cnt <= (r_cnt == C_LAST) ? 4'd0 : r_cnt + 4'd1;
    end
  end

  assign tick = r_sync[1] & ~r_sync[2];
  assign step = tick & (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/iori_anim_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iori_anim_ctrl : player-2 sprite state, frame index and action pulses |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module iori_anim_ctrl #(
  parameter int FRAME_DIV      = 4,
  parameter int STAND_FRAMES   = 8,
  parameter int FWD_FRAMES     = 10,
  parameter int BWD_FRAMES     = 9,
  parameter int ATTACK_FRAMES  = 6,
  parameter int DEFENSE_FRAMES = 1,
  parameter int HURT_FRAMES    = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       key_defend,
  input  logic       hit,
  output logic [7:0] character2_state,
  output logic [7:0] frame_num,
  output logic       move_l2,
  output logic       move_r2,
  output logic       attack,
  output logic       hurt,
  output logic       blocked
);

  import iori_pkg::*;

  state_t     r_state, w_next_state;
  logic [7:0] r_frame, w_next_frame;
  logic [7:0] w_frames, w_last;
  logic       r_hit_pending, w_hit;
  logic       w_tick, w_step, w_clr, w_blocked, w_oneshot, w_done;
  logic       r_move_l2, r_move_r2, r_attack, r_hurt, r_blocked;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .clr       (w_clr),
    .tick      (w_tick),
    .step      (w_step)
  );

  always_comb begin
    case (r_state)
      ST_ATTACK:  w_frames = 8'(ATTACK_FRAMES);
      ST_MOVEL:   w_frames = 8'(FWD_FRAMES);
      ST_MOVER:   w_frames = 8'(BWD_FRAMES);
      ST_DEFENSE: w_frames = 8'(DEFENSE_FRAMES);
      ST_HURT:    w_frames = 8'(HURT_FRAMES);
      default:    w_frames = 8'(STAND_FRAMES);
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_frame = r_frame;
    w_clr        = 1'b0;
    w_blocked    = 1'b0;
    w_last       = w_frames - 8'd1;
    w_hit        = r_hit_pending | hit;
    w_oneshot    = (r_state == ST_ATTACK) || (r_state == ST_HURT);
    w_done       = w_oneshot && w_step && (r_frame == w_last);

    if (w_tick) begin
      if (w_hit && (r_state != ST_HURT) && (r_state != ST_DEFENSE))
        w_next_state = ST_HURT;
      else if (w_hit && (r_state == ST_DEFENSE))
        w_blocked = 1'b1;
      else if (w_oneshot && !w_done)
        w_next_state = r_state;
      else if (key_attack)
        w_next_state = ST_ATTACK;
      else if (key_defend)
        w_next_state = ST_DEFENSE;
      else if (key_left ^ key_right)
        w_next_state = key_left ? ST_MOVEL : ST_MOVER;
      else
        w_next_state = ST_STAND;

      // A finished one-shot restarts at frame 0 even if it re-enters itself
      if ((w_next_state != r_state) || w_done) begin
        w_next_frame = 8'd0;
        w_clr        = 1'b1;
      end else if (w_step) begin
        w_next_frame = (r_frame == w_last) ? 8'd0 : r_frame + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_STAND;
      r_frame       <= 8'd0;
      r_hit_pending <= 1'b0;
      r_move_l2     <= 1'b0;
      r_move_r2     <= 1'b0;
      r_attack      <= 1'b0;
      r_hurt        <= 1'b0;
      r_blocked     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_frame   <= w_next_frame;
      if (w_tick)
        r_hit_pending <= 1'b0;
      else if (hit)
        r_hit_pending <= 1'b1;
      r_move_l2 <= w_tick && (w_next_state == ST_MOVEL);
      r_move_r2 <= w_tick && (w_next_state == ST_MOVER);
      r_attack  <= w_tick && (w_next_state == ST_ATTACK);
      r_hurt    <= w_tick && (w_next_state == ST_HURT);
      r_blocked <= w_blocked;
    end
  end

  assign character2_state = r_state;
  assign frame_num        = r_frame;
  assign move_l2          = r_move_l2;
  assign move_r2          = r_move_r2;
  assign attack           = r_attack;
  assign hurt             = r_hurt;
  assign blocked          = r_blocked;

endmodule
`default_nettype wire
